// File: rtl/cordic_rot_bist.sv
// -----------------------------------------------------------------------------
// cordic_rot_bist
//   Pipelined CORDIC rotation engine: rotates (x0,y0) by angle z0 (radians,
//   Q(WIDTH-FRAC).FRAC) through STAGES micro-rotation stages, producing the
//   unscaled result (CORDIC gain ~1.64676 is left in). A built-in self-test
//   FSM can push a fixed 4-vector table through the same pipeline and check
//   the results against expected values within TOL LSB.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   external sample strobe, accepted only while in_ready=1
//   in_ready   high while the self-test is not running
//   x0,y0,z0   external operands (signed, WIDTH bits)
//   out_valid  one-cycle result strobe per accepted sample
//   out_tag    1 = result belongs to a self-test vector
//   x,y        rotated outputs, hold their value while out_valid=0
//   start      self-test request (rising edge of the level)
//   busy       self-test in progress
//   done       one-cycle pulse when the self-test completes
//   pass       1 if every self-test vector was within TOL (held)
//   fail_cnt   number of failing vectors in the last self-test run
// -----------------------------------------------------------------------------
module cordic_rot_bist #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int STAGES = 16,
    parameter int TOL    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] z0,
    output logic                    out_valid,
    output logic                    out_tag,
    output logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [2:0]              fail_cnt
);

    // Constants are kept in Q.16 and scaled up to the configured FRAC.
    function automatic logic signed [WIDTH-1:0] scale_q16(input int v);
        logic signed [WIDTH-1:0] t;
        t = WIDTH'(v);
        return t <<< (FRAC - 16);
    endfunction

    function automatic int atan_q16(input int k);
        case (k)
            0:       return 51472;
            1:       return 30386;
            2:       return 16055;
            3:       return 8150;
            4:       return 4091;
            5:       return 2047;
            6:       return 1024;
            7:       return 512;
            8:       return 256;
            9:       return 128;
            10:      return 64;
            11:      return 32;
            12:      return 16;
            13:      return 8;
            14:      return 4;
            15:      return 2;
            default: return 0;
        endcase
    endfunction

    // Self-test table: every vector starts from (1.0, 0).
    function automatic logic signed [WIDTH-1:0] vec_z(input logic [1:0] idx);
        case (idx)
            2'd0:    return '0;
            2'd1:    return scale_q16(102943);
            2'd2:    return scale_q16(-102943);
            default: return scale_q16(51472);
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] vec_xe(input logic [1:0] idx);
        case (idx)
            2'd0:    return scale_q16(107923);
            2'd1:    return '0;
            2'd2:    return '0;
            default: return scale_q16(76313);
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] vec_ye(input logic [1:0] idx);
        case (idx)
            2'd0:    return '0;
            2'd1:    return scale_q16(107923);
            2'd2:    return scale_q16(-107923);
            default: return scale_q16(76313);
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  issue_idx_q;
    logic [1:0]  chk_cnt_q;
    logic        start_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [2:0]  fail_cnt_q;
    logic [2:0]  fail_cnt_d;

    // Pipeline: index 0 is the input register, index i is after micro-rotation i.
    logic signed [WIDTH-1:0] xs_q [0:STAGES];
    logic signed [WIDTH-1:0] ys_q [0:STAGES];
    logic signed [WIDTH-1:0] zs_q [0:STAGES];
    logic signed [WIDTH-1:0] xs_d [0:STAGES];
    logic signed [WIDTH-1:0] ys_d [0:STAGES];
    logic signed [WIDTH-1:0] zs_d [0:STAGES];
    logic [STAGES:0]         vs_q;
    logic [STAGES:0]         ts_q;
    logic                    s0_v_d;
    logic                    s0_t_d;

    logic                    out_valid_q;
    logic                    out_tag_q;
    logic signed [WIDTH-1:0] x_q;
    logic signed [WIDTH-1:0] y_q;

    logic start_edge;
    assign start_edge = start & ~start_q;

    // Input mux: self-test vectors take the pipeline while ISSUE is active;
    // external samples are blocked for the whole busy window.
    always_comb begin
        xs_d[0] = x0;
        ys_d[0] = y0;
        zs_d[0] = z0;
        s0_v_d  = in_valid & ~busy_q;
        s0_t_d  = 1'b0;
        if (state_q == ST_ISSUE) begin
            xs_d[0] = scale_q16(65536);
            ys_d[0] = '0;
            zs_d[0] = vec_z(issue_idx_q);
            s0_v_d  = 1'b1;
            s0_t_d  = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_stage
            localparam int SH = gi - 1;
            localparam logic signed [WIDTH-1:0] ATAN_C = scale_q16(atan_q16(SH));
            logic d_pos;
            // z >= 0 rotates counter-clockwise (d = +1)
            assign d_pos    = ~zs_q[gi-1][WIDTH-1];
            assign xs_d[gi] = d_pos ? xs_q[gi-1] - (ys_q[gi-1] >>> SH)
                                    : xs_q[gi-1] + (ys_q[gi-1] >>> SH);
            assign ys_d[gi] = d_pos ? ys_q[gi-1] + (xs_q[gi-1] >>> SH)
                                    : ys_q[gi-1] - (xs_q[gi-1] >>> SH);
            assign zs_d[gi] = d_pos ? zs_q[gi-1] - ATAN_C
                                    : zs_q[gi-1] + ATAN_C;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= STAGES; i++) begin
                xs_q[i] <= '0;
                ys_q[i] <= '0;
                zs_q[i] <= '0;
            end
            vs_q <= '0;
            ts_q <= '0;
        end else begin
            for (int i = 0; i <= STAGES; i++) begin
                xs_q[i] <= xs_d[i];
                ys_q[i] <= ys_d[i];
                zs_q[i] <= zs_d[i];
            end
            vs_q <= {vs_q[STAGES-1:0], s0_v_d};
            ts_q <= {ts_q[STAGES-1:0], s0_t_d};
        end
    end

    // Output register: data only updates on a valid result so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            out_valid_q <= vs_q[STAGES];
            out_tag_q   <= vs_q[STAGES] & ts_q[STAGES];
            if (vs_q[STAGES]) begin
                x_q <= xs_q[STAGES];
                y_q <= ys_q[STAGES];
            end
        end
    end

    // Checker looks at the last stage, i.e. the value being loaded into x/y,
    // so the verdict is ready on the same edge the tagged result is output.
    logic                    chk_hit;
    logic                    chk_fail;
    logic signed [WIDTH-1:0] xe;
    logic signed [WIDTH-1:0] ye;
    logic signed [WIDTH:0]   dx;
    logic signed [WIDTH:0]   dy;
    logic [WIDTH:0]          adx;
    logic [WIDTH:0]          ady;

    always_comb begin
        xe       = vec_xe(chk_cnt_q);
        ye       = vec_ye(chk_cnt_q);
        dx       = {xs_q[STAGES][WIDTH-1], xs_q[STAGES]} - {xe[WIDTH-1], xe};
        dy       = {ys_q[STAGES][WIDTH-1], ys_q[STAGES]} - {ye[WIDTH-1], ye};
        adx      = dx[WIDTH] ? -dx : dx;
        ady      = dy[WIDTH] ? -dy : dy;
        chk_hit  = vs_q[STAGES] & ts_q[STAGES] & (state_q == ST_DRAIN);
        chk_fail = (adx > (WIDTH+1)'(TOL)) || (ady > (WIDTH+1)'(TOL));
        fail_cnt_d = fail_cnt_q + {2'b00, chk_fail};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_idx_q <= '0;
            chk_cnt_q   <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            start_q <= start;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q     <= ST_ISSUE;
                        issue_idx_q <= '0;
                        chk_cnt_q   <= '0;
                        fail_cnt_q  <= '0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    issue_idx_q <= issue_idx_q + 2'd1;
                    if (issue_idx_q == 2'd3) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (chk_hit) begin
                        chk_cnt_q  <= chk_cnt_q + 2'd1;
                        fail_cnt_q <= fail_cnt_d;
                        if (chk_cnt_q == 2'd3) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            pass_q  <= (fail_cnt_d == 3'd0);
                        end
                    end
                end
                ST_DONE: begin
                    // start edges seen here are dropped; start_q still tracks
                    // the level so a held start cannot re-arm in IDLE.
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = ~busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_cnt  = fail_cnt_q;
    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign x         = x_q;
    assign y         = y_q;

endmodule
